instr_fetch_control: RTL

- Front end that drives the register-file/ALU datapath's control inputs: PC register, small program-loadable instruction memory, instruction decoder, and branch resolution from the datapath's zero_flag.
- Each RUN cycle presents one instruction's rs1/rs2/rd/alu_control/regwrite combinationally, then advances the PC at the clock edge.
- Provides a start/halt run-control FSM so benches can load a program, run it, and detect completion.

---
 rtl/riscv_ctrl_pkg.sv | 48 ++++
 rtl/instr_decoder.sv | 67 ++++++
 rtl/instr_fetch_control.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the instruction fetch/control front end.
//   - RV32 opcode and function-field constants for the supported subset
//   - ALU operation codes consumed by the datapath
//   - run-control FSM encoding and the decoder's output bundle
package riscv_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned ALU_W  = 4;

  localparam logic [6:0]      OP_RTYPE   = 7'b0110011;
  localparam logic [6:0]      OP_BRANCH  = 7'b1100011;
  localparam logic [XLEN-1:0] ECALL_WORD = 32'h0000_0073;

  localparam logic [2:0] F3_BEQ = 3'b000;

  // {funct7, funct3} for the supported R-type operations
  localparam logic [9:0] FN_ADD = {7'b0000000, 3'b000};
  localparam logic [9:0] FN_SUB = {7'b0100000, 3'b000};
  localparam logic [9:0] FN_AND = {7'b0000000, 3'b111};
  localparam logic [9:0] FN_OR  = {7'b0000000, 3'b110};
  localparam logic [9:0] FN_SLT = {7'b0000000, 3'b010};

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [ALU_W-1:0]  alu_control;
    logic              regwrite;
    logic              is_branch;
    logic              is_ecall;
    logic              illegal;
    logic [XLEN-1:0]   imm_b;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decoder for the supported RV32 subset (R-type ALU ops, BEQ, ECALL).
//   instr : 32-bit instruction word
//   dec   : register fields, alu_control, regwrite, class flags and the
//           sign-extended B-type immediate
// Register fields are zero for anything that does not read/write registers.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output decode_t         dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rtype_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec      = '0;
    rtype_ok = 1'b0;
    // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended
    dec.imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    case (opcode)
      OP_RTYPE: begin
        rtype_ok = 1'b1;
        case ({funct7, funct3})
          FN_ADD:  dec.alu_control = ALU_ADD;
          FN_SUB:  dec.alu_control = ALU_SUB;
          FN_AND:  dec.alu_control = ALU_AND;
          FN_OR:   dec.alu_control = ALU_OR;
          FN_SLT:  dec.alu_control = ALU_SLT;
          default: rtype_ok = 1'b0;
        endcase
        if (rtype_ok) begin
          dec.rs1      = instr[19:15];
          dec.rs2      = instr[24:20];
          dec.rd       = instr[11:7];
          dec.regwrite = 1'b1;
        end else begin
          dec.alu_control = '0;
          dec.illegal     = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          // compare is done by the datapath as a subtraction
          dec.rs1         = instr[19:15];
          dec.rs2         = instr[24:20];
          dec.alu_control = ALU_SUB;
          dec.is_branch   = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: begin
        if (instr == ECALL_WORD) dec.is_ecall = 1'b1;
        else                     dec.illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_control.sv
// Fetch/control front end: PC, program-loadable instruction memory, decode and
// BEQ resolution, plus an IDLE/RUN/HALT run-control FSM.
//   clock, reset         : clock, asynchronous active-high reset
//   start                : from IDLE/HALT, restart execution at RESET_PC
//   prog_we/addr/data    : program write port, honoured outside RUN
//   zero_flag            : datapath zero result for the current instruction
//   read_reg_num1/2,
//   write_reg,
//   alu_control,
//   regwrite             : datapath controls, zero unless running
//   pc                   : current PC
//   running, halted      : FSM status
//   illegal_instr        : sticky, set when a halt was caused by an illegal condition
module instr_fetch_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          zero_flag,
  output logic [4:0]                    read_reg_num1,
  output logic [4:0]                    read_reg_num2,
  output logic [4:0]                    write_reg,
  output logic [3:0]                    alu_control,
  output logic                          regwrite,
  output logic [31:0]                   pc,
  output logic                          running,
  output logic                          halted,
  output logic                          illegal_instr
);

  localparam int unsigned     AW       = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(4 * IMEM_DEPTH);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] seq_pc, br_target, next_pc;
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] instr;
  decode_t         dec;
  logic            run_c;

  assign run_c = (state_q == RUN);

  // Program store: writes only while not executing; contents survive reset
  always_ff @(posedge clock) begin
    if (prog_we && !run_c && !reset) imem[prog_addr] <= prog_data;
  end

  // Asynchronous word fetch so decode is available in the same cycle
  assign instr = imem[pc_q[AW+1:2]];

  instr_decoder u_decoder (
    .instr (instr),
    .dec   (dec)
  );

  assign seq_pc    = pc_q + XLEN'(4);
  assign br_target = pc_q + dec.imm_b;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: run control and PC update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    next_pc   = seq_pc;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
        end
      end
      RUN: begin
        if (dec.is_branch && zero_flag) next_pc = br_target;

        if (dec.illegal) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else if (dec.is_ecall) begin
          state_d = HALT;
        end else if ((next_pc[1:0] != 2'b00) || (next_pc >= PC_LIMIT)) begin
          // misaligned target or fetch outside imem (negative wraps high); pc holds
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          pc_d = next_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controls are gated by RUN, so an async reset silences them at once
  assign read_reg_num1 = run_c ? dec.rs1         : '0;
  assign read_reg_num2 = run_c ? dec.rs2         : '0;
  assign write_reg     = run_c ? dec.rd          : '0;
  assign alu_control   = run_c ? dec.alu_control : '0;
  assign regwrite      = run_c ? dec.regwrite    : 1'b0;

  assign pc            = pc_q;
  assign running       = run_c;
  assign halted        = (state_q == HALT);
  assign illegal_instr = illegal_q;

endmodule
